// File: rtl/axi4_lite_traffic_gen.sv
// AXI4-Lite initiator issuing pseudo-random write-then-readback pairs from an xorshift64 stream
// and counting readback mismatches.
module axi4_lite_traffic_gen #(
  parameter int unsigned ADDR_WIDTH       = 16,
  parameter int unsigned NUM_TRANSACTIONS = 256,
  parameter logic [63:0] SEED             = 64'd88172645463325252
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] error_count,
  output logic        mem_axi_awvalid,
  input  logic        mem_axi_awready,
  output logic [31:0] mem_axi_awaddr,
  output logic [2:0]  mem_axi_awprot,
  output logic        mem_axi_wvalid,
  input  logic        mem_axi_wready,
  output logic [31:0] mem_axi_wdata,
  output logic [3:0]  mem_axi_wstrb,
  input  logic        mem_axi_bvalid,
  output logic        mem_axi_bready,
  output logic        mem_axi_arvalid,
  input  logic        mem_axi_arready,
  output logic [31:0] mem_axi_araddr,
  output logic [2:0]  mem_axi_arprot,
  input  logic        mem_axi_rvalid,
  output logic        mem_axi_rready,
  input  logic [31:0] mem_axi_rdata
);

  localparam logic [63:0] DefaultSeed = 64'd88172645463325252;
  localparam logic [63:0] SeedInit    = (SEED == 64'd0) ? DefaultSeed : SEED;
  // Keep only the word-aligned low ADDR_WIDTH bits.
  localparam logic [31:0] AddrMask    = (32'hFFFF_FFFF >> (32 - ADDR_WIDTH)) & 32'hFFFF_FFFC;

  typedef enum logic [2:0] {
    StIdle, StGen, StDelay, StWrite, StBresp, StRead, StRdata, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] xs_q, xs_d, xs_next;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  delay_q, delay_d;
  logic [31:0] cnt_q, cnt_d;
  logic [15:0] err_q, err_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;

  function automatic logic [63:0] xorshift(input logic [63:0] x);
    logic [63:0] a, b;
    a = x ^ (x << 13);
    b = a ^ (a >> 7);
    return b ^ (b << 17);
  endfunction

  assign xs_next = xorshift(xs_q);

  always_comb begin
    state_d   = state_q;
    xs_d      = xs_q;
    addr_d    = addr_q;
    data_d    = data_q;
    delay_d   = delay_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          err_d   = '0;
          cnt_d   = '0;
          state_d = StGen;
        end
      end
      StGen: begin
        xs_d    = xs_next;
        addr_d  = xs_next[31:0] & AddrMask;
        data_d  = xs_next[63:32];
        delay_d = xs_next[2:0];
        state_d = StDelay;
      end
      StDelay: begin
        if (delay_q == 3'd0) begin
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StWrite;
        end else begin
          delay_d = delay_q - 3'd1;
        end
      end
      StWrite: begin
        // Each channel retires independently; both may complete in the same cycle.
        awvalid_d = awvalid_q && !mem_axi_awready;
        wvalid_d  = wvalid_q && !mem_axi_wready;
        if (!awvalid_d && !wvalid_d) state_d = StBresp;
      end
      StBresp: begin
        if (mem_axi_bvalid) begin
          arvalid_d = 1'b1;
          state_d   = StRead;
        end
      end
      StRead: begin
        if (mem_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (mem_axi_rvalid) begin
          if (mem_axi_rdata != data_q && err_q != 16'hFFFF) err_d = err_q + 16'd1;
          cnt_d   = cnt_q + 32'd1;
          state_d = (cnt_d == NUM_TRANSACTIONS) ? StDone : StGen;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      xs_q      <= SeedInit;
      addr_q    <= '0;
      data_q    <= '0;
      delay_q   <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      xs_q      <= xs_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      delay_q   <= delay_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
    end
  end

  assign busy            = (state_q != StIdle) && (state_q != StDone);
  assign done            = (state_q == StDone);
  assign error_count     = err_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = 3'd0;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = data_q;
  assign mem_axi_wstrb   = 4'hF;
  assign mem_axi_bready  = (state_q == StBresp);
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = 3'd0;
  assign mem_axi_rready  = (state_q == StRdata);

endmodule

// File: tb/tb_axi4_lite_traffic_gen.sv
// Bench for axi4_lite_traffic_gen: memory responder with optional stalls, protocol monitor and an
// xorshift64 reference model of the expected address/data stream.
module tb_axi4_lite_traffic_gen;

  localparam int unsigned NumTx = 4;
  localparam logic [63:0] Seed  = 64'd88172645463325252;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        busy, done;
  logic [15:0] error_count;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  axi4_lite_traffic_gen #(
    .ADDR_WIDTH      (16),
    .NUM_TRANSACTIONS(NumTx),
    .SEED            (Seed)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .error_count    (error_count),
    .mem_axi_awvalid(awvalid),
    .mem_axi_awready(awready),
    .mem_axi_awaddr (awaddr),
    .mem_axi_awprot (awprot),
    .mem_axi_wvalid (wvalid),
    .mem_axi_wready (wready),
    .mem_axi_wdata  (wdata),
    .mem_axi_wstrb  (wstrb),
    .mem_axi_bvalid (bvalid),
    .mem_axi_bready (bready),
    .mem_axi_arvalid(arvalid),
    .mem_axi_arready(arready),
    .mem_axi_araddr (araddr),
    .mem_axi_arprot (arprot),
    .mem_axi_rvalid (rvalid),
    .mem_axi_rready (rready),
    .mem_axi_rdata  (rdata)
  );

  // Responder configuration, driven by the stimulus block.
  logic        stall_en    = 1'b0;
  int unsigned aw_hold_cfg = 0;
  int          flip_at     = -1;

  // Responder state.
  logic [31:0] mem [0:16383];
  logic        aw_have, w_have, ar_have, ar_flip;
  logic [31:0] aw_addr_r, w_data_r, ar_addr_r;
  int unsigned aw_wait, w_wait, b_wait, ar_wait, r_wait, aw_held;

  // Monitor logs and protocol-violation count.
  logic [31:0] aw_log [0:1023];
  logic [31:0] w_log  [0:1023];
  logic [31:0] ar_log [0:1023];
  int          aw_n = 0, w_n = 0, ar_n = 0;
  int          aw_hi = 0, w_hi = 0, viol = 0;
  logic        p_aw, p_awr, p_w, p_wr, p_ar, p_arr, b_done;
  logic [31:0] p_awaddr, p_wdata, p_araddr;

  int          checks = 0, errors = 0;
  logic [63:0] model_xs;
  int          aw_rd = 0, w_rd = 0, ar_rd = 0;
  logic [31:0] t1_aw [0:3];
  logic [31:0] t1_w  [0:3];

  function automatic int unsigned stall();
    return stall_en ? $urandom_range(0, 7) : 0;
  endfunction

  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  always_comb begin
    awready = !aw_have && aw_wait == 0 && aw_held >= aw_hold_cfg;
    wready  = !w_have && w_wait == 0;
    arready = !ar_have && ar_wait == 0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aw_have <= 0; w_have <= 0; ar_have <= 0; ar_flip <= 0;
      aw_wait <= 0; w_wait <= 0; b_wait <= 0; ar_wait <= 0; r_wait <= 0; aw_held <= 0;
      bvalid <= 0; rvalid <= 0; rdata <= '0;
      aw_addr_r <= '0; w_data_r <= '0; ar_addr_r <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_have <= 1; aw_addr_r <= awaddr; aw_held <= 0;
      end else if (awvalid) begin
        if (aw_wait != 0) aw_wait <= aw_wait - 1;
        if (aw_held < aw_hold_cfg) aw_held <= aw_held + 1;
      end
      if (wvalid && wready) begin
        w_have <= 1; w_data_r <= wdata;
      end else if (wvalid && w_wait != 0) begin
        w_wait <= w_wait - 1;
      end
      if (aw_have && w_have && !bvalid) begin
        if (b_wait == 0) begin
          mem[aw_addr_r[15:2]] <= w_data_r;
          bvalid <= 1;
        end else b_wait <= b_wait - 1;
      end
      if (bvalid && bready) begin
        bvalid <= 0; aw_have <= 0; w_have <= 0;
        aw_wait <= stall(); w_wait <= stall(); b_wait <= stall();
      end
      if (arvalid && arready) begin
        ar_have <= 1; ar_addr_r <= araddr; ar_flip <= (ar_n == flip_at);
      end else if (arvalid && ar_wait != 0) begin
        ar_wait <= ar_wait - 1;
      end
      if (ar_have && !rvalid) begin
        if (r_wait == 0) begin
          rvalid <= 1;
          rdata  <= mem[ar_addr_r[15:2]] ^ {31'd0, ar_flip};
        end else r_wait <= r_wait - 1;
      end
      if (rvalid && rready) begin
        rvalid <= 0; ar_have <= 0; ar_wait <= stall(); r_wait <= stall();
      end
    end
  end

  // Monitor: logs handshakes and flags valid drops, payload changes, early AR and early bready.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p_aw <= 0; p_awr <= 0; p_w <= 0; p_wr <= 0; p_ar <= 0; p_arr <= 0; b_done <= 0;
      p_awaddr <= '0; p_wdata <= '0; p_araddr <= '0;
    end else begin
      if (awvalid && awready) begin aw_log[aw_n] <= awaddr; aw_n <= aw_n + 1; end
      if (wvalid && wready) begin w_log[w_n] <= wdata; w_n <= w_n + 1; end
      if (arvalid && arready) begin ar_log[ar_n] <= araddr; ar_n <= ar_n + 1; end
      if (awvalid) aw_hi <= aw_hi + 1;
      if (wvalid) w_hi <= w_hi + 1;
      if ((p_aw && !p_awr && (!awvalid || awaddr != p_awaddr)) ||
          (p_w && !p_wr && (!wvalid || wdata != p_wdata)) ||
          (p_ar && !p_arr && (!arvalid || araddr != p_araddr)) ||
          (arvalid && !b_done) || (bready && (awvalid || wvalid)))
        viol <= viol + 1;
      if (bvalid && bready) b_done <= 1;
      if (arvalid && arready) b_done <= 0;
      p_aw <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
      p_w  <= wvalid;  p_wr  <= wready;  p_wdata  <= wdata;
      p_ar <= arvalid; p_arr <= arready; p_araddr <= araddr;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic check_pairs(input string tag, input int n);
    logic [31:0] ea, ed;
    check({tag, " aw count"}, aw_n - aw_rd, n);
    check({tag, " w count"}, w_n - w_rd, n);
    check({tag, " ar count"}, ar_n - ar_rd, n);
    for (int i = 0; i < n; i++) begin
      model_xs = xs_step(model_xs);
      ea = {16'd0, model_xs[15:2], 2'b00};
      ed = model_xs[63:32];
      check({tag, " awaddr"}, aw_log[aw_rd], ea);
      check({tag, " wdata"}, w_log[w_rd], ed);
      check({tag, " araddr"}, ar_log[ar_rd], ea);
      aw_rd++; w_rd++; ar_rd++;
    end
  endtask

  initial begin
    int k, base, a0, w0;
    reset = 1'b1;
    start = 1'b0;
    model_xs = Seed;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error_count", error_count, 0);
    check("rst valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("rst awaddr", awaddr, 0);
    check("rst wdata", wdata, 0);
    check("prot/strb", {awprot, arprot, wstrb}, 10'h00F);

    // Ideal responder.
    pulse_start();
    check("t1 busy", busy, 1);
    wait_done("t1");
    check("t1 error_count", error_count, 0);
    for (int i = 0; i < 4; i++) begin
      t1_aw[i] = aw_log[aw_rd + i];
      t1_w[i]  = w_log[w_rd + i];
    end
    check_pairs("t1", NumTx);

    // Second readback corrupted.
    flip_at = ar_n + 1;
    pulse_start();
    wait_done("t2");
    check("t2 error_count", error_count, 1);
    check_pairs("t2", NumTx);
    flip_at = -1;

    // awready withheld for 5 cycles of every write.
    aw_hold_cfg = 5;
    a0 = aw_hi;
    w0 = w_hi;
    pulse_start();
    wait_done("t3");
    check("t3 awvalid cycles", aw_hi - a0, 6 * NumTx);
    check("t3 wvalid cycles", w_hi - w0, NumTx);
    check("t3 protocol", viol, 0);
    check_pairs("t3", NumTx);
    aw_hold_cfg = 0;

    // Reset while awvalid is high, then repeat from the seed.
    pulse_start();
    k = 0;
    while (!awvalid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t4 awvalid seen", awvalid, 1);
    reset = 1'b1;
    #1;
    check("t4 valids dropped", {awvalid, wvalid, arvalid, bready, rready}, 0);
    check("t4 busy dropped", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    aw_rd = aw_n; w_rd = w_n; ar_rd = ar_n;
    model_xs = Seed;
    pulse_start();
    wait_done("t4");
    for (int i = 0; i < 4; i++) begin
      check("t4 repeat awaddr", aw_log[aw_rd + i], t1_aw[i]);
      check("t4 repeat wdata", w_log[w_rd + i], t1_w[i]);
    end
    check_pairs("t4", NumTx);

    // start while busy must not restart the run or clear the error count.
    base = ar_n;
    flip_at = ar_n;
    pulse_start();
    k = 0;
    while (ar_n < base + 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("t5 reached 2nd read", ar_n >= base + 2, 1);
    pulse_start();
    wait_done("t5");
    check("t5 error_count", error_count, 1);
    check_pairs("t5", NumTx);
    flip_at = -1;

    // Random stalls on every channel, 64 runs of 4 pairs.
    stall_en = 1'b1;
    for (int r = 0; r < 64; r++) begin
      pulse_start();
      wait_done("t6");
      check("t6 error_count", error_count, 0);
      check_pairs("t6", NumTx);
    end
    check("t6 protocol", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
